// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states and
// the default write-protected word index.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int unsigned PROT_WORD_DEF = 2048;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RSP  = 2'b11
    } state_t;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte/halfword lane logic: extends the addressed lane of a word for loads and
// merges store data into the addressed lane for read-modify-write.
module mem_lane_unit
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sign_b;
    logic        sign_h;

    always_comb begin
        byte_v  = old_word[{offset, 3'b000} +: 8];
        half_v  = old_word[{offset[1], 4'b0000} +: 16];
        sign_b  = ~is_unsigned & byte_v[7];
        sign_h  = ~is_unsigned & half_v[15];
        ld_data = old_word;
        st_word = wdata;
        case (size)
            SZ_B: begin
                ld_data = {{24{sign_b}}, byte_v};
                st_word = old_word;
                st_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                ld_data = {{16{sign_h}}, half_v};
                st_word = old_word;
                st_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ld_data = old_word;
                st_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the core memory stage and a word-only data memory;
// one request in flight, read-modify-write for sub-word stores.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned PROT_WORD = PROT_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    state_t      state_q, state_d;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_q;
    logic        accept, bad;
    logic [31:0] ld_data, st_word;

    assign accept = req_valid && req_ready;

    // Rejected requests never reach memory.
    always_comb begin
        bad = 1'b0;
        if (req_size == 2'b11)                                bad = 1'b1;
        if (req_size == SZ_H && req_addr[0])                  bad = 1'b1;
        if (req_size == SZ_W && req_addr[1:0] != 2'b00)       bad = 1'b1;
        if (req_we && req_addr[31:2] == 30'(PROT_WORD))       bad = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad)                                state_d = ST_RSP;
                    else if (req_we && req_size == SZ_W)    state_d = ST_WR;
                    else                                    state_d = ST_RD;
                end
            end
            ST_RD:   state_d = we_q ? ST_WR : ST_RSP;
            ST_WR:   state_d = ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latches; the memory word is captured once, in RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= bad;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == ST_RD) word_q <= mem_rd;
        end
    end

    mem_lane_unit u_lane (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (uns_q),
        .old_word    (word_q),
        .wdata       (wdata_q),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    // Outputs decoded from state so a reset removes them without a clock edge.
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !rst;
        mem_we    = (state_q == ST_WR);
        mem_a     = 32'h0;
        mem_wd    = 32'h0;
        rsp_valid = (state_q == ST_RSP);
        rsp_err   = (state_q == ST_RSP) && err_q;
        rsp_rdata = 32'h0;
        if (state_q == ST_RD || state_q == ST_WR) mem_a = {addr_q[31:2], 2'b00};
        if (state_q == ST_WR)                     mem_wd = st_word;
        if (state_q == ST_RSP && !we_q && !err_q) rsp_rdata = ld_data;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer between the RV32I core's memory stage and the word-only data memory (`datamem`). It turns byte, halfword and word requests into word transactions, and performs read-modify-write for sub-word stores. It sign- or zero-extends loads and flags misaligned or protected accesses. One request is in flight at a time, with a valid/ready request channel and a single-cycle response pulse.

## Interface
Parameters:
- `PROT_WORD`, default 2048: word index that is write-protected in data memory (byte address 0x2000).

Ports (reset is asynchronous, active-high):
- `clk`  in  1  — rising-edge clock, the only clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — controller can accept a request.
- `req_we`  in  1  — 1 = store, 0 = load.
- `req_size`  in  2  — 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  — load zero-extends when set.
- `req_addr`  in  32  — byte address.
- `req_wdata`  in  32  — store data, right-aligned.
- `rsp_valid`  out  1  — one-cycle response pulse.
- `rsp_rdata`  out  32  — extended load data.
- `rsp_err`  out  1  — request rejected; memory untouched.
- `mem_a`  out  32  — word address to memory, bits [1:0] always 00.
- `mem_wd`  out  32  — write data to memory.
- `mem_we`  out  1  — memory write enable.
- `mem_rd`  in  32  — combinational read data from memory.

## Operation
- FSM states: IDLE, RD, WR, RSP.
- `req_ready` = (state == IDLE) and not `rst`.
- Handshake: when `req_valid` and `req_ready` are both high at a rising edge, the controller latches addr, size, we, unsigned and wdata. Inputs are don't-care afterwards.
- Error check, done in IDLE at acceptance. Any of these gives IDLE→RSP with `rsp_err`=1 and `rsp_rdata`=0, and `mem_we` never asserts:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - store whose word index addr[31:2] == `PROT_WORD`.
- Word or sub-word load: IDLE→RD→RSP. In RD, `mem_rd` is captured.
  - Lane select is addr[1:0] for a byte, addr[1] for a half.
  - The selected lane is sign-extended unless `req_unsigned` is set.
- Word store: IDLE→WR→RSP. In WR, `mem_wd` = wdata.
- Sub-word store: IDLE→RD→WR→RSP.
  - RD captures the old word.
  - WR drives the old word with the addressed lane replaced by wdata[7:0] or wdata[15:0].
- `mem_we` is decoded from state (WR only), so it is high for exactly one cycle per store.
- `mem_a` holds the latched word address throughout RD and WR, and is 0 in IDLE.
- RSP lasts one cycle, asserts `rsp_valid`, then returns to IDLE.
  - For stores: `rsp_rdata` = 0.
  - No response backpressure.
- Reset values: state IDLE; `req_ready` 0 while `rst` is high; `rsp_valid`, `rsp_err` and `mem_we` are 0; `rsp_rdata`, `mem_a` and `mem_wd` are 0.
- Reset mid-operation: the FSM goes to IDLE immediately.
  - Because `mem_we` is decoded from state, it drops without waiting for a clock edge.
  - The pending request is dropped with no response.

## Timing
Edge 0 is the acceptance edge; cycle N is the Nth cycle after edge 0.
- Error: `rsp_valid` in cycle 1. Total latency 1.
- Load or word store: RD/WR in cycle 1, `rsp_valid` in cycle 2.
- Sub-word store: RD in cycle 1, WR in cycle 2 (the memory write takes effect at the end of cycle 2), `rsp_valid` in cycle 3.
- `req_ready` rises in the cycle after RSP. Back-to-back throughput is one request per (latency+1) cycles.
- `rsp_rdata` and `rsp_err` are valid only while `rsp_valid` is high; they are 0 otherwise.

## Structure
- `mem_ctrl_pkg` holds:
  - size encodings (`SZ_B`, `SZ_H`, `SZ_W`);
  - FSM state enum;
  - `PROT_WORD` default constant.
- Sub-module `mem_lane_unit` is combinational. It takes size, offset, unsigned, old word and wdata, and produces the extended load data and the merged store word.
- The FSM, request latches and error check live in the top module.

## Test plan
- Reset: hold `rst`=1 → `req_ready`=0, `mem_we`=0, `rsp_valid`=0. Release → `req_ready`=1 in the next cycle.
- SW 0x100 ← 0x11223344 → `mem_we`=1 with `mem_wd`=0x11223344 in cycle 1, `rsp_valid`/`rsp_err`=1/0 in cycle 2. Then LW 0x100 → `rsp_rdata`=0x11223344 in cycle 2.
- SB 0x101 ← 0x000000AB onto 0x11223344 → RD in cycle 1, `mem_wd`=0x1122AB44 in cycle 2, response in cycle 3. SH 0x102 ← 0xBEEF → 0xBEEFAB44.
- Word 0x8000ABCD at 0x104:
  - LH 0x106 → 0xFFFF8000;
  - LHU 0x106 → 0x00008000;
  - LB 0x104 → 0xFFFFFFCD;
  - LBU 0x105 → 0x000000AB.
- Errors → `rsp_err`=1 in cycle 1, `mem_we` never high:
  - LW 0x102;
  - LH 0x101;
  - size 11;
  - SW 0x2000;
  - SB 0x2003.
- Assert `rst` during the RD cycle of SB 0x101 → `mem_we` stays 0, no `rsp_valid`. After release, a new LW is accepted and the memory word is unchanged.
